// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it, ops 4-7 return or_illegal.
module alu_muldiv #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_md_op,
   input  logic [XLEN-1:0] i_data_1,
   input  logic [XLEN-1:0] i_data_2,
   input  logic [TAGW-1:0] i_rd_addr,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] or_result,
   output logic [TAGW-1:0] or_rd_addr,
   output logic            or_illegal
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic [TAGW-1:0]   tag;
   logic [2*XLEN-1:0] acc, mcand, acc_nxt, addend;
   logic [XLEN-1:0]   mplier;
   logic              b_signed, last, accept, special, spec_ill;
   logic [XLEN-1:0]   spec_res, fin_res, quo_fin, rem_fin;

`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0] rem, quo, dvs, rem_nxt, quo_nxt, a_mag, b_mag;
   logic [XLEN:0]   rem_sh, diff;
   logic            neg_q, neg_r, sgn_div, a_neg, b_neg, div0, ovf;

   always_comb begin
      sgn_div  = ~i_md_op[0];
      a_neg    = sgn_div & i_data_1[XLEN-1];
      b_neg    = sgn_div & i_data_2[XLEN-1];
      a_mag    = a_neg ? -i_data_1 : i_data_1;
      b_mag    = b_neg ? -i_data_2 : i_data_2;
      div0     = (i_data_2 == '0);
      ovf      = sgn_div && (i_data_1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_data_2 == '1);
      special  = i_md_op[2] & (div0 | ovf);
      spec_ill = 1'b0;
      if (div0) spec_res = i_md_op[1] ? i_data_1 : '1;
      else      spec_res = i_md_op[1] ? '0 : i_data_1;
      // diff is never below -dvs, so its top bit is a reliable borrow
      rem_sh   = {rem, quo[XLEN-1]};
      diff     = rem_sh - {1'b0, dvs};
      rem_nxt  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_nxt  = {quo[XLEN-2:0], ~diff[XLEN]};
      quo_fin  = neg_q ? -quo_nxt : quo_nxt;
      rem_fin  = neg_r ? -rem_nxt : rem_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         rem   <= '0;
         quo   <= a_mag;
         dvs   <= b_mag;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (state == CALC) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
      end
   end
`else
   always_comb begin
      special  = i_md_op[2];
      spec_ill = 1'b1;
      spec_res = '0;
      quo_fin  = '0;
      rem_fin  = '0;
   end
`endif

   // Signed multiplier: the top bit carries negative weight, so subtract on the last step
   always_comb begin
      last    = (cnt == CW'(XLEN - 1));
      addend  = mplier[0] ? mcand : '0;
      acc_nxt = (last && b_signed) ? acc - addend : acc + addend;
      case (op)
         3'd0:          fin_res = acc_nxt[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fin_res = acc_nxt[2*XLEN-1:XLEN];
         3'd4, 3'd5:    fin_res = quo_fin;
         default:       fin_res = rem_fin;
      endcase
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (i_valid) begin
            accept    = 1'b1;
            state_nxt = special ? DONE : CALC;
         end
         CALC: if (last) state_nxt = DONE;
         DONE: if (i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (i_flush) begin
         accept    = 1'b0;
         state_nxt = IDLE;
      end
   end

   assign o_ready = (state == IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         o_valid    <= 1'b0;
         or_result  <= '0;
         or_rd_addr <= '0;
         or_illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         o_valid <= (state_nxt == DONE);
         if (accept)             cnt <= '0;
         else if (state == CALC) cnt <= cnt + 1'b1;
         if (accept && special) begin
            or_result  <= spec_res;
            or_rd_addr <= i_rd_addr;
            or_illegal <= spec_ill;
         end else if (state == CALC && last && !i_flush) begin
            or_result  <= fin_res;
            or_rd_addr <= tag;
            or_illegal <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         op       <= i_md_op;
         tag      <= i_rd_addr;
         acc      <= '0;
         mcand    <= {{XLEN{(i_md_op == 3'd1 || i_md_op == 3'd2) & i_data_1[XLEN-1]}}, i_data_1};
         mplier   <= i_data_2;
         b_signed <= (i_md_op == 3'd1);
      end else if (state == CALC) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
endmodule
